// File: rtl/div_pkg.sv
// Shared types and constants for the divider front-end scheduler.
package div_pkg;

    // Scheduler states: idle/issue, waiting on the divider, holding a result.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } sched_state_t;

    // Fill bit for the quotient reported on a divide-by-zero request;
    // replicated to the operand width at the point of use.
    localparam bit DZ_COC = '0;

endpackage

// File: rtl/div_fifo.sv
// Synchronous FIFO with extra-MSB pointers; no fall-through.
module div_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state pointer arithmetic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/div_scheduler.sv
// Front-end for the sequential signed divider: queues tagged operand
// pairs, issues one Start pulse at a time, intercepts divide-by-zero and
// returns each result with its tag on a valid/ready port.
module div_scheduler
    import div_pkg::*;
#(
    parameter int unsigned tamanyo = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAGW    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [tamanyo-1:0] in_num,
    input  logic [tamanyo-1:0] in_den,
    input  logic [TAGW-1:0]    in_tag,
    output logic               div_start,
    output logic [tamanyo-1:0] div_num,
    output logic [tamanyo-1:0] div_den,
    input  logic               div_done,
    input  logic [tamanyo-1:0] div_coc,
    input  logic [tamanyo-1:0] div_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [tamanyo-1:0] out_coc,
    output logic [tamanyo-1:0] out_res,
    output logic [TAGW-1:0]    out_tag,
    output logic               out_dz
);

    localparam int unsigned W = TAGW + 2 * tamanyo;

    sched_state_t       state_q;
    logic               div_start_q;
    logic [tamanyo-1:0] div_num_q, div_den_q;
    logic [TAGW-1:0]    tag_q;
    logic               out_valid_q, out_dz_q;
    logic [tamanyo-1:0] out_coc_q, out_res_q;
    logic [TAGW-1:0]    out_tag_q;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [W-1:0]       fifo_rdata;
    logic [tamanyo-1:0] head_num, head_den;
    logic [TAGW-1:0]    head_tag;

    assign in_ready  = !fifo_full && !RST;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    assign head_num = fifo_rdata[tamanyo-1:0];
    assign head_den = fifo_rdata[2*tamanyo-1:tamanyo];
    assign head_tag = fifo_rdata[W-1:2*tamanyo];

    div_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (fifo_push),
        .wdata_i ({in_tag, in_den, in_num}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Issue / wait / hold sequencer with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            div_start_q <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_coc_q   <= '0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_den != '0) begin
                            div_num_q   <= head_num;
                            div_den_q   <= head_den;
                            div_start_q <= 1'b1;
                            tag_q       <= head_tag;
                            state_q     <= WAIT;
                        end else begin
                            // Answer locally so the divider never sees Den == 0.
                            out_coc_q   <= {tamanyo{DZ_COC}};
                            out_res_q   <= head_num;
                            out_dz_q    <= 1'b1;
                            out_tag_q   <= head_tag;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end
                WAIT: begin
                    div_start_q <= 1'b0;
                    if (div_done) begin
                        out_coc_q   <= div_coc;
                        out_res_q   <= div_res;
                        out_dz_q    <= 1'b0;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_start = div_start_q;
    assign div_num   = div_num_q;
    assign div_den   = div_den_q;
    assign out_valid = out_valid_q;
    assign out_coc   = out_coc_q;
    assign out_res   = out_res_q;
    assign out_tag   = out_tag_q;
    assign out_dz    = out_dz_q;

endmodule

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
- Front-end stage placed directly upstream of the sequential signed divider (CLK/Start/Num/Den in, Coc/Res/Done out).
- Buffers tagged operand pairs in a FIFO and issues them one at a time as a single-cycle Start pulse.
- Waits for Done, captures Coc/Res, and presents each result with its tag on a valid/ready output port.
- Intercepts divide-by-zero so the divider never sees Den == 0.

Parameters:
- tamanyo, 32, operand/result width; must match the divider instance.
- DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- TAGW, 4, width of the request tag carried through to the result.

Ports:
- CLK  in  1  clock, shared with the divider.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_num  in  tamanyo  signed dividend.
- in_den  in  tamanyo  signed divisor.
- in_tag  in  TAGW  request tag.
- div_start  out  1  Start to divider; registered, one-cycle pulse.
- div_num  out  tamanyo  Num to divider; registered, stable from issue until Done.
- div_den  out  tamanyo  Den to divider; registered, stable from issue until Done.
- div_done  in  1  Done from divider.
- div_coc  in  tamanyo  Coc from divider.
- div_res  in  tamanyo  Res from divider.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_coc  out  tamanyo  quotient.
- out_res  out  tamanyo  remainder.
- out_tag  out  TAGW  tag of the request.
- out_dz  out  1  result came from a divide-by-zero request.

Behaviour:
- Reset is synchronous on RST=1 at a CLK edge.
  - Reset values: in_ready=0 during reset, then 1 (FIFO empty).
  - div_start=0, div_num=0, div_den=0, out_valid=0, out_coc=0, out_res=0, out_tag=0, out_dz=0.
  - FIFO empty, state IDLE.
- Reset mid-operation abandons the request in flight and discards FIFO contents.
- The divider's RSTa is driven from the same reset source (inverted at top level), so no stale Done can arrive after reset.
- FIFO:
  - Push when in_valid && in_ready.
  - Read/write pointers are log2(DEPTH)+1 bits; full when MSBs differ and the low bits are equal.
  - Push and pop in the same cycle are allowed when neither full nor empty.
  - No fall-through: data pushed at edge t is poppable from edge t+1.
- FSM states (package enum): IDLE, WAIT, HOLD.
- IDLE:
  - If FIFO not empty: pop.
  - If popped den != 0: load div_num/div_den, div_start<=1, tag<=entry tag, go to WAIT.
  - If popped den == 0: out_coc<=0, out_res<=popped num, out_dz<=1, out_tag<=tag, out_valid<=1, go to HOLD. The divider is not started.
- WAIT:
  - div_start<=0, so Start is high for exactly one cycle.
  - On div_done=1: out_coc<=div_coc, out_res<=div_res, out_dz<=0, out_valid<=1, go to HOLD.
  - Divider latency is 2*tamanyo+2 cycles from the Start-sampled edge to Done (66 cycles for tamanyo=32).
- HOLD:
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready: out_valid<=0, go to IDLE.
- div_done outside WAIT is ignored.
- Only one request is ever in flight; the next issue happens at the earliest one cycle after the HOLD handshake.
- Sign convention: quotient truncates toward zero, remainder takes the sign of the dividend. This is the divider's convention, passed through unmodified.
- Most-negative dividend (e.g. 0x80000000) is passed through unmodified; its result is defined by the divider.

Decomposition:
- Package div_pkg: sched_state_t enum {IDLE, WAIT, HOLD} and the constant DZ_COC = '0.
- Sub-module div_fifo #(W, DEPTH): synchronous FIFO with push/pop/full/empty.
  - One instance, word = {tag, den, num}.
- No other sub-modules.

Test Plan:
- Push (100, 7, tag 3) with out_ready=1 -> single div_start pulse; out_valid with coc=14, res=2, tag=3, dz=0 about 70 cycles later.
- Push (-100, 7), (100, -7), (-100, -7) back-to-back -> results in order:
  - (-14, -2)
  - (-14, 2)
  - (14, -2)
  - exactly one div_start per request.
- Push (55, 0, tag 9) -> no div_start; out_valid within 2 cycles with coc=0, res=55, dz=1, tag=9.
- Hold out_ready=0 and push DEPTH+2 requests -> in_ready drops after DEPTH+1 accepts (DEPTH in FIFO + 1 in flight); outputs stay stable; releasing out_ready drains all requests in order with no loss.
- Assert RST for 1 cycle during WAIT with 2 entries queued -> all outputs at reset values next cycle, FIFO empty, no result emitted; a new request afterwards completes correctly.
- Push (0x7FFFFFFF, 1) and (1, 0x7FFFFFFF) -> (0x7FFFFFFF, 0) and (0, 1).
